// File: rtl/frs_message_queue.sv
// FRS Message queue: buffers received FRS Messages for the FRS Queuing capability,
// presents the oldest entry as the queue register and raises received/overflow set pulses.
module frs_message_queue #(
  parameter int DEPTH     = 8,
  parameter int FUNC_ID_W = 16,
  parameter int REASON_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 link_dl_down,
  input  logic                 msg_valid,
  input  logic [FUNC_ID_W-1:0] msg_func_id,
  input  logic [REASON_W-1:0]  msg_reason,
  input  logic                 sw_dequeue,
  output logic [31:0]          queue_reg,
  output logic [11:0]          queue_depth,
  output logic [11:0]          queue_max_depth,
  output logic                 queue_empty,
  output logic                 queue_full,
  output logic                 frs_message_received_set,
  output logic                 frs_message_overflow_set
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = FUNC_ID_W + REASON_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic          rcv_q, ovf_q;
  logic          enq, deq, ovf;
  logic [EW-1:0] new_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign new_entry = {msg_reason, msg_func_id};

  // A same-cycle dequeue frees the slot, so a full queue still accepts the message.
  assign deq = !link_dl_down && sw_dequeue && (count_q != '0);
  assign enq = !link_dl_down && msg_valid && ((count_q != FULL_CNT) || deq);
  assign ovf = !link_dl_down && msg_valid && (count_q == FULL_CNT) && !deq;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (link_dl_down) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (enq && !deq) count_d = count_q + CW'(1);
      if (deq && !enq) count_d = count_q - CW'(1);
      // New head may be the slot being written this cycle, which memory does not hold yet.
      if (count_d == '0)                   head_d = '0;
      else if (enq && rd_ptr_d == wr_ptr_q) head_d = new_entry;
      else                                  head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      rcv_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      rcv_q    <= enq;
      ovf_q    <= ovf;
    end
  end

  assign queue_reg                = 32'(head_q);
  assign queue_depth              = 12'(count_q);
  assign queue_max_depth          = 12'(DEPTH);
  assign queue_empty              = (count_q == '0);
  assign queue_full               = (count_q == FULL_CNT);
  assign frs_message_received_set = rcv_q;
  assign frs_message_overflow_set = ovf_q;

endmodule
